// File: rtl/nd_loop_counter.sv
// Purpose : N-dimensional nested-loop counter emitting index tuples and a linear address (base + sum idx*stride).
// Latency : first tuple valid the cycle after an accepted start; one tuple per valid&ready handshake.
// Backpr. : ready=0 holds count/addr/last/dim_wrap stable; abort ends the job without a done pulse.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, abort      job start (IDLE only) and job terminate
//   cfg_max           per-dim trip count, dim d at [d*WIDTH +: WIDTH]
//   cfg_stride        per-dim address stride, dim d at [d*ADDR_W +: ADDR_W]
//   cfg_base          job start address
//   ready / valid     tuple handshake
//   count, addr       current index tuple and its linear address
//   last, dim_wrap    final-tuple flag and per-dim wrap flags
//   busy, done        job in progress; one-cycle completion pulse
//   cfg_err           one-cycle pulse when a start is rejected (some max == 0)
module nd_loop_counter #(
    parameter int NDIM   = 3,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NDIM*WIDTH-1:0]   cfg_max,
    input  logic [NDIM*ADDR_W-1:0]  cfg_stride,
    input  logic [ADDR_W-1:0]       cfg_base,
    input  logic                    ready,
    output logic                    valid,
    output logic [NDIM*WIDTH-1:0]   count,
    output logic [ADDR_W-1:0]       addr,
    output logic                    last,
    output logic [NDIM-1:0]         dim_wrap,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;

    logic [NDIM-1:0][WIDTH-1:0]  cnt_q,    cnt_d;
    logic [NDIM-1:0][WIDTH-1:0]  max_q,    max_d;
    logic [NDIM-1:0][ADDR_W-1:0] stride_q, stride_d;
    // part_q[d] tracks cnt_q[d]*stride_q[d] incrementally so no multiplier is needed.
    logic [NDIM-1:0][ADDR_W-1:0] part_q,   part_d;
    logic [ADDR_W-1:0]           base_q,   base_d;
    logic                        done_q,   done_d;
    logic                        err_q,    err_d;

    // Advance values and wrap flags derived from the current tuple.
    logic [NDIM-1:0][WIDTH-1:0]  adv_cnt;
    logic [NDIM-1:0][ADDR_W-1:0] adv_part;
    logic [NDIM-1:0]             wrap_c;
    logic                        any_zero;
    logic [ADDR_W-1:0]           addr_sum;
    logic                        running;

    assign running = (state_q == RUN);

    // Carry chain: a dim steps only when every inner dim wraps; a dim at
    // max-1 that steps returns to zero and passes the carry outward.
    always_comb begin
        logic carry;
        logic at_max;
        carry    = 1'b1;
        adv_cnt  = cnt_q;
        adv_part = part_q;
        wrap_c   = '0;
        for (int d = 0; d < NDIM; d++) begin
            at_max = (cnt_q[d] == (max_q[d] - WIDTH'(1)));
            if (carry) begin
                if (at_max) begin
                    adv_cnt[d]  = '0;
                    adv_part[d] = '0;
                end else begin
                    adv_cnt[d]  = cnt_q[d] + WIDTH'(1);
                    adv_part[d] = part_q[d] + stride_q[d];
                end
            end
            carry     = carry & at_max;
            wrap_c[d] = carry;
        end
    end

    always_comb begin
        any_zero = 1'b0;
        for (int d = 0; d < NDIM; d++) begin
            if (cfg_max[d*WIDTH +: WIDTH] == '0) begin
                any_zero = 1'b1;
            end
        end
    end

    always_comb begin
        addr_sum = base_q;
        for (int d = 0; d < NDIM; d++) begin
            addr_sum = addr_sum + part_q[d];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        part_d   = part_q;
        max_d    = max_q;
        stride_d = stride_q;
        base_d   = base_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // abort in IDLE swallows a simultaneous start.
                if (start && !abort) begin
                    if (any_zero) begin
                        err_d = 1'b1;
                    end else begin
                        max_d    = cfg_max;
                        stride_d = cfg_stride;
                        base_d   = cfg_base;
                        cnt_d    = '0;
                        part_d   = '0;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    part_d  = '0;
                end else if (ready) begin
                    if (wrap_c[NDIM-1]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        part_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = adv_cnt;
                        part_d = adv_part;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            part_q   <= '0;
            max_q    <= '0;
            stride_q <= '0;
            base_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            part_q   <= part_d;
            max_q    <= max_d;
            stride_q <= stride_d;
            base_q   <= base_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Config stays latched after a job, so address and wrap flags are gated
    // to read zero outside RUN.
    assign valid    = running;
    assign busy     = running;
    assign count    = cnt_q;
    assign addr     = running ? addr_sum : '0;
    assign dim_wrap = running ? wrap_c : '0;
    assign last     = running & wrap_c[NDIM-1];
    assign done     = done_q;
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_nd_loop_counter.sv
// Purpose : directed + randomized bench for nd_loop_counter against a div/mod tuple model.
// Latency : checks outputs on every falling edge; inputs driven at falling edges.
// Backpr. : ready toggled randomly; expected tuple only advances on handshake.
module tb_nd_loop_counter;
    localparam int NDIM = 3;
    localparam int W    = 32;
    localparam int A    = 32;

    logic              clk = 1'b0;
    logic              rst, start, abort, ready;
    logic [NDIM*W-1:0] cfg_max;
    logic [NDIM*A-1:0] cfg_stride;
    logic [A-1:0]      cfg_base;
    logic              valid, last, busy, done, cfg_err;
    logic [NDIM*W-1:0] count;
    logic [A-1:0]      addr;
    logic [NDIM-1:0]   dim_wrap;

    int tests = 0;
    int fails = 0;

    nd_loop_counter #(.NDIM(NDIM), .WIDTH(W), .ADDR_W(A)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_max(cfg_max), .cfg_stride(cfg_stride), .cfg_base(cfg_base),
        .ready(ready), .valid(valid), .count(count), .addr(addr),
        .last(last), .dim_wrap(dim_wrap), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, valid, 1'b0);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".done"}, done, 1'b0);
        chk({tag, ".cfg_err"}, cfg_err, 1'b0);
        chk({tag, ".count"}, count, '0);
        chk({tag, ".addr"}, addr, '0);
        chk({tag, ".last"}, last, 1'b0);
        chk({tag, ".dim_wrap"}, dim_wrap, '0);
    endtask

    // Tuple k of a job in loop order: index d = (k / prod(max[j<d])) mod max[d].
    task automatic model(input logic [NDIM*W-1:0] mx, input logic [NDIM*A-1:0] st,
                         input logic [A-1:0] bs, input int k,
                         output logic [NDIM*W-1:0] ec, output logic [A-1:0] ea,
                         output logic [NDIM-1:0] ew);
        int rem;
        int m;
        int idx;
        bit all_top;
        rem     = k;
        ea      = bs;
        ec      = '0;
        all_top = 1'b1;
        for (int d = 0; d < NDIM; d++) begin
            m   = int'(mx[d*W +: W]);
            idx = rem % m;
            rem = rem / m;
            ec[d*W +: W] = W'(idx);
            ea = ea + A'(idx) * st[d*A +: A];
            all_top = all_top & (idx == m - 1);
            ew[d] = all_top;
        end
    endtask

    task automatic kick(input logic [NDIM*W-1:0] mx, input logic [NDIM*A-1:0] st,
                        input logic [A-1:0] bs);
        cfg_max    = mx;
        cfg_stride = st;
        cfg_base   = bs;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Called at the first RUN cycle; returns in the done cycle (or the cycle after abort).
    task automatic stream(input logic [NDIM*W-1:0] mx, input logic [NDIM*A-1:0] st,
                          input logic [A-1:0] bs, input bit stall,
                          input int abort_after, input bit btb);
        int total;
        int k;
        logic [NDIM*W-1:0] ec;
        logic [A-1:0]      ea;
        logic [NDIM-1:0]   ew;
        total = 1;
        k     = 0;
        for (int d = 0; d < NDIM; d++) total *= int'(mx[d*W +: W]);
        for (int cyc = 0; cyc < 1000; cyc++) begin
            model(mx, st, bs, k, ec, ea, ew);
            chk("run.valid", valid, 1'b1);
            chk("run.busy", busy, 1'b1);
            chk("run.done", done, 1'b0);
            chk("run.count", count, ec);
            chk("run.addr", addr, ea);
            chk("run.dim_wrap", dim_wrap, ew);
            chk("run.last", last, ew[NDIM-1]);
            if (abort_after == k) begin
                abort = 1'b1;
                ready = 1'($urandom_range(0, 1));
                start = 1'b0;
                @(negedge clk);
                abort = 1'b0;
                ready = 1'b0;
                chk("abort.valid", valid, 1'b0);
                chk("abort.busy", busy, 1'b0);
                chk("abort.done", done, 1'b0);
                return;
            end
            ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            // Disturb the live config and start; a running job must ignore both.
            cfg_max    = {$urandom, $urandom, $urandom};
            cfg_stride = {$urandom, $urandom, $urandom};
            cfg_base   = $urandom;
            if (ready && k == total - 1) begin
                start = btb;
                @(negedge clk);
                ready = 1'b0;
                chk("end.valid", valid, 1'b0);
                chk("end.busy", busy, 1'b0);
                chk("end.done", done, 1'b1);
                chk("end.count", count, '0);
                chk("end.addr", addr, '0);
                chk("end.last", last, 1'b0);
                return;
            end
            start = 1'($urandom_range(0, 1));
            if (ready) k++;
            @(negedge clk);
        end
        tests++;
        fails++;
        $error("FAIL stream_timeout observed=%0d expected=%0d", k, total);
    endtask

    logic [NDIM*W-1:0] mx_a, mx_one, mx_b, mx_r;
    logic [NDIM*A-1:0] st_a, st_b, st_r;
    logic [A-1:0]      bs_r;

    initial begin
        mx_a   = {32'd2, 32'd3, 32'd2};
        st_a   = {32'd16, 32'd4, 32'd1};
        mx_one = {32'd1, 32'd1, 32'd1};
        mx_b   = {32'd1, 32'd1, 32'd3};
        st_b   = {32'd0, 32'd0, 32'hFFFF_FFFF};
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
        cfg_max = '0; cfg_stride = '0; cfg_base = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");

        // 12-tuple job, ready always high
        kick(mx_a, st_a, 32'h100);
        stream(mx_a, st_a, 32'h100, 1'b0, -1, 1'b0);
        @(negedge clk);
        chk("a.done_clear", done, 1'b0);

        // Same job with random stalls
        kick(mx_a, st_a, 32'h100);
        stream(mx_a, st_a, 32'h100, 1'b1, -1, 1'b0);
        @(negedge clk);
        chk("stall.done_clear", done, 1'b0);

        // Single-element job
        kick(mx_one, st_a, 32'h40);
        chk("one.dim_wrap", dim_wrap, 3'b111);
        stream(mx_one, st_a, 32'h40, 1'b0, -1, 1'b0);
        @(negedge clk);

        // Rejected config (dim 1 max = 0)
        kick({32'd2, 32'd0, 32'd4}, st_a, 32'h0);
        chk("err.pulse", cfg_err, 1'b1);
        chk("err.busy", busy, 1'b0);
        chk("err.valid", valid, 1'b0);
        @(negedge clk);
        chk("err.clear", cfg_err, 1'b0);
        chk("err.busy2", busy, 1'b0);

        // Abort after 5 handshakes, then restart from the top
        kick(mx_a, st_a, 32'h100);
        stream(mx_a, st_a, 32'h100, 1'b1, 5, 1'b0);
        @(negedge clk);
        chk("abort.no_done", done, 1'b0);
        kick(mx_a, st_a, 32'h100);
        stream(mx_a, st_a, 32'h100, 1'b0, -1, 1'b0);
        @(negedge clk);

        // Abort in IDLE wins over start
        cfg_max = mx_a; cfg_stride = st_a; cfg_base = 32'h100;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk_idle("idle_abort");

        // Reset mid-job, with start held during reset
        kick(mx_a, st_a, 32'h100);
        ready = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk_idle("mid_rst");
        @(negedge clk);
        chk_idle("mid_rst2");
        rst = 1'b0; start = 1'b0; ready = 1'b0;
        @(negedge clk);
        chk_idle("after_rst");

        // Back-to-back: start held through done, second job with negative stride
        kick(mx_a, st_a, 32'h100);
        stream(mx_a, st_a, 32'h100, 1'b0, -1, 1'b1);
        cfg_max = mx_b; cfg_stride = st_b; cfg_base = 32'h20;
        @(negedge clk);
        start = 1'b0;
        stream(mx_b, st_b, 32'h20, 1'b0, -1, 1'b0);
        @(negedge clk);
        chk("btb.done_clear", done, 1'b0);

        // Random configurations with stalls
        for (int r = 0; r < 4; r++) begin
            mx_r = {W'($urandom_range(1, 3)), W'($urandom_range(1, 4)), W'($urandom_range(1, 3))};
            st_r = {$urandom, $urandom, $urandom};
            bs_r = $urandom;
            kick(mx_r, st_r, bs_r);
            stream(mx_r, st_r, bs_r, 1'b1, -1, 1'b0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
